adc_conv_sequencer: RTL and testbench

Synchronous conversion sequencer for the SAR ADC clock generator with its start-edge detector. It accepts conversion requests over a valid/ready handshake and drives `start_conv` and `ena_in` into the asynchronous clock generator. It then synchronizes the core's asynchronous `conv_done` back into the system clock domain, captures the result, optionally averages 2^N conversions and presents the value over a valid/ready output. A watchdog aborts conversions that never finish.

---
 rtl/adc_seq_pkg.sv | 24 ++
 rtl/adc_conv_sequencer_if.sv | 22 ++
 rtl/adc_sync2.sv | 19 +
 rtl/adc_conv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the SAR ADC conversion sequencer.
// ADC_SEQ_AVG_EN widens the accumulator for 2^osr averaging.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPT,
        ST_RECOV,
        ST_OUT
    } adc_seq_state_t;

    localparam int unsigned ADC_SEQ_OSR_MAX = 4;

    function automatic int unsigned adc_seq_acc_w(input int unsigned resw);
`ifdef ADC_SEQ_AVG_EN
        return resw + ADC_SEQ_OSR_MAX;
`else
        return resw;
`endif
    endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Request/result handshake bundle between a requester and adc_conv_sequencer.
interface adc_conv_sequencer_if #(
    parameter int unsigned RESW  = 12,
    parameter int unsigned OSR_W = 3
);
    logic [OSR_W-1:0] cfg_osr;
    logic             req_valid;
    logic             req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [RESW-1:0]  res_data;

    modport master (
        output cfg_osr, req_valid, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  cfg_osr, req_valid, res_ready,
        output req_ready, res_valid, res_data
    );
endinterface

// File: rtl/adc_sync2.sv
// Two-flop synchronizer for ADC-domain levels entering the clk domain.
module adc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for the SAR ADC clock generator with watchdog.
// Define ADC_SEQ_AVG_EN to enable 2^osr oversampling/averaging.
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned RESW           = 12,
    parameter int unsigned START_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned OSR_W          = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    adc_conv_sequencer_if.slave  bus,
    output logic                 adc_start_conv,
    output logic                 adc_ena,
    input  logic                 conv_done,
    input  logic [RESW-1:0]      adc_result,
    output logic                 timeout_err
);
    localparam int unsigned ACC_W = adc_seq_acc_w(RESW);
    localparam int unsigned SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    adc_seq_state_t   state;
    logic             done_s;
    logic [SC_W-1:0]  scnt;
    logic [WD_W-1:0]  wd;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [4:0]       cnt;
    logic [4:0]       cnt_nxt;
    logic [4:0]       cnt_tgt;
    logic [2:0]       osr;
    logic             req_ready_q;
    logic             res_valid_q;
    logic [RESW-1:0]  res_data_q;

`ifndef ADC_SEQ_AVG_EN
    assign osr = '0;
`endif

    adc_sync2 u_done_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (conv_done),
        .q     (done_s)
    );

    assign acc_sum = acc + ACC_W'(adc_result);
    assign cnt_nxt = cnt + 5'd1;
    assign cnt_tgt = 5'd1 << osr;

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_ready_q    <= 1'b0;
            adc_start_conv <= 1'b0;
            adc_ena        <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            timeout_err    <= 1'b0;
            scnt           <= '0;
            wd             <= '0;
            acc            <= '0;
            cnt            <= '0;
`ifdef ADC_SEQ_AVG_EN
            osr            <= '0;
`endif
        end else if (!ena) begin
            // Disabled: silent abort, pending result dropped, no watchdog pulse.
            state          <= ST_IDLE;
            req_ready_q    <= 1'b0;
            adc_start_conv <= 1'b0;
            adc_ena        <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            timeout_err    <= 1'b0;
            scnt           <= '0;
            wd             <= '0;
            acc            <= '0;
            cnt            <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q    <= 1'b0;
                        adc_start_conv <= 1'b1;
                        adc_ena        <= 1'b1;
                        scnt           <= '0;
                        acc            <= '0;
                        cnt            <= '0;
`ifdef ADC_SEQ_AVG_EN
                        // OSR_W must be at least 3 to express the maximum.
                        if (bus.cfg_osr > OSR_W'(ADC_SEQ_OSR_MAX))
                            osr <= 3'(ADC_SEQ_OSR_MAX);
                        else
                            osr <= 3'(bus.cfg_osr);
`endif
                        state          <= ST_START;
                    end
                end
                ST_START: begin
                    if (scnt == SC_LAST) begin
                        adc_start_conv <= 1'b0;
                        wd             <= '0;
                        state          <= ST_WAIT;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // done_s is checked first so it wins over a same-cycle expiry.
                    if (done_s) begin
                        state <= ST_CAPT;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        adc_ena     <= 1'b0;
                        acc         <= '0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_CAPT: begin
                    adc_ena <= 1'b0;
                    acc     <= acc_sum;
                    cnt     <= cnt_nxt;
                    if (cnt_nxt == cnt_tgt) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= RESW'(acc_sum >> osr);
                        state       <= ST_OUT;
                    end else begin
                        wd    <= '0;
                        state <= ST_RECOV;
                    end
                end
                ST_RECOV: begin
                    if (!done_s) begin
                        adc_start_conv <= 1'b1;
                        adc_ena        <= 1'b1;
                        scnt           <= '0;
                        state          <= ST_START;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a behavioural SAR core model.
// Averaging steps are included when ADC_SEQ_AVG_EN is defined.
module tb_adc_conv_sequencer;
    localparam int unsigned RESW = 12;
`ifdef ADC_SEQ_AVG_EN
    localparam logic [2:0] OSR_SINGLE = 3'd0;
`else
    localparam logic [2:0] OSR_SINGLE = 3'd3;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b0;
    logic            adc_start_conv;
    logic            adc_ena;
    logic            conv_done = 1'b0;
    logic [RESW-1:0] adc_result = '0;
    logic            timeout_err;

    int n_pass = 0;
    int n_total = 0;
    int model_delay = 30;
    int conv_idx = 0;
    int n_starts = 0;
    int pre_high = 0;
    int hi_cnt = 0;
    int n_to = 0;
    int stable;
    int k;
    int base;
    logic [RESW-1:0] model_res [0:3];

    always #5 clk = ~clk;

    adc_conv_sequencer_if #(.RESW(RESW), .OSR_W(3)) bus ();

    adc_conv_sequencer #(
        .RESW           (RESW),
        .START_CYCLES   (4),
        .TIMEOUT_CYCLES (1024),
        .OSR_W          (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .bus            (bus),
        .adc_start_conv (adc_start_conv),
        .adc_ena        (adc_ena),
        .conv_done      (conv_done),
        .adc_result     (adc_result),
        .timeout_err    (timeout_err)
    );

    // SAR core: done rises model_delay cycles after start, falls when the loop stops.
    always @(posedge adc_start_conv) begin
        n_starts++;
        if (conv_done) pre_high++;
        conv_done = 1'b0;
        if (model_delay > 0) begin
            repeat (model_delay) @(posedge clk);
            #2;
            adc_result = model_res[conv_idx[1:0]];
            conv_idx++;
            conv_done = 1'b1;
        end
    end

    always @(negedge adc_ena) conv_done = 1'b0;
    always @(posedge clk) if (adc_start_conv) hi_cnt++;
    always @(posedge clk) if (timeout_err) n_to++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_start(input logic lvl, input string tag);
        int n = 0;
        while (adc_start_conv !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(adc_start_conv), 32'(lvl));
    endtask

    task automatic wait_res(input int limit, input string tag);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.res_valid), 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.cfg_osr   = OSR_SINGLE;
        ena           = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(bus.req_ready),  32'd0);
        check("rst_start_conv", 32'(adc_start_conv), 32'd0);
        check("rst_adc_ena",    32'(adc_ena),        32'd0);
        check("rst_res_valid",  32'(bus.res_valid),  32'd0);
        check("rst_res_data",   32'(bus.res_data),   32'd0);
        check("rst_timeout",    32'(timeout_err),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Single conversion
        model_res[0] = 12'hA5C;
        conv_idx = 0;
        hi_cnt = 0;
        n_starts = 0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("accept_start_rise", 32'(adc_start_conv), 32'd1);
        check("busy_req_ready",    32'(bus.req_ready),  32'd0);
        check("busy_adc_ena",      32'(adc_ena),        32'd1);
        bus.req_valid = 1'b0;
        wait_res(200, "single_res_valid");
        check("single_res_data",    32'(bus.res_data), 32'hA5C);
        check("single_start_width", 32'(hi_cnt),       32'd4);
        check("single_start_count", 32'(n_starts),     32'd1);

        // Backpressure with a pending request
        bus.req_valid = 1'b1;
        model_res[0] = 12'h3C7;
        conv_idx = 0;
        stable = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1 && bus.res_data === 12'hA5C && bus.req_ready === 1'b0)
                stable++;
        end
        check("bp_stable",    32'(stable),   32'd20);
        check("bp_no_accept", 32'(n_starts), 32'd1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("hs_res_valid_low", 32'(bus.res_valid),  32'd0);
        check("hs_req_ready",     32'(bus.req_ready),  32'd1);
        check("hs_no_start_yet",  32'(adc_start_conv), 32'd0);
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("reaccept_start", 32'(adc_start_conv), 32'd1);
        bus.req_valid = 1'b0;

        // cfg_osr=3 is ignored without averaging: one conversion yields the result
        wait_res(200, "second_res_valid");
        check("second_res_data",    32'(bus.res_data), 32'h3C7);
        check("second_start_count", 32'(n_starts),     32'd2);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;

`ifdef ADC_SEQ_AVG_EN
        // Averaging, osr=2: (100+101+102+104)>>2 = 101
        model_res[0] = 12'd100;
        model_res[1] = 12'd101;
        model_res[2] = 12'd102;
        model_res[3] = 12'd104;
        conv_idx = 0;
        model_delay = 10;
        base = n_starts;
        pre_high = 0;
        hi_cnt = 0;
        bus.cfg_osr = 3'd2;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_res(600, "avg_res_valid");
        check("avg_res_data",    32'(bus.res_data),    32'd101);
        check("avg_start_count", 32'(n_starts - base), 32'd4);
        check("avg_done_low",    32'(pre_high),        32'd0);
        check("avg_start_width", 32'(hi_cnt),          32'd16);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.cfg_osr = OSR_SINGLE;
`endif

        // Timeout: conv_done never rises
        model_delay = 0;
        n_to = 0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_start(1'b0, "to_wait_entry");
        k = 0;
        while (timeout_err !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", 32'(k), 32'd1024);
        @(negedge clk);
        check("to_pulse_low", 32'(timeout_err),   32'd0);
        check("to_count",     32'(n_to),          32'd1);
        check("to_no_result", 32'(bus.res_valid), 32'd0);
        check("to_req_ready", 32'(bus.req_ready), 32'd1);
        check("to_adc_ena",   32'(adc_ena),       32'd0);

        // Abort: ena dropped in WAIT
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_start(1'b0, "ab_wait_entry");
        repeat (5) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ab_adc_ena",   32'(adc_ena),        32'd0);
        check("ab_start",     32'(adc_start_conv), 32'd0);
        check("ab_req_ready", 32'(bus.req_ready),  32'd0);
        check("ab_res_valid", 32'(bus.res_valid),  32'd0);
        repeat (20) @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        check("ab_req_ready_back", 32'(bus.req_ready), 32'd1);

        // Abort: asynchronous reset in START
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("rs_start_high", 32'(adc_start_conv), 32'd1);
        bus.req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rs_start_low",  32'(adc_start_conv), 32'd0);
        check("rs_adc_ena",    32'(adc_ena),        32'd0);
        check("rs_req_ready",  32'(bus.req_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_req_ready_back", 32'(bus.req_ready), 32'd1);
        check("ab_no_timeout",     32'(n_to),          32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
